// File: rtl/alu_legv8_core.sv
// alu_legv8_core: 64-bit LEGv8 execute-stage ALU.
// Logic, add/subtract with carry-in, XOR and logical shifts, chosen by a 5-bit
// function select FS. The result F and flags {V,C,N,Z} are registered, giving
// one cycle of latency and one operation per cycle.
// Optional feature macro: ALU_ASR_EN. When defined, FS[4:2]=110 is an
// arithmetic shift right. When undefined, it returns zero, the same as 111.
module alu_legv8_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status,
  output logic             out_valid
);

  localparam int SHW = 6;

  // Packed in {V,C,N,Z} order so the struct maps straight onto the status port.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  logic [WIDTH-1:0] a2, b2;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] f_d, f_q;
  flags_t           st_d, st_q;
  logic             vld_q;

  // Operand conditioning: optional inversion of each operand.
  // Subtraction is ~B with a carry-in of 1.
  always_comb begin
    a2 = FS[1] ? ~A : A;
    b2 = FS[0] ? ~B : B;
  end

  // A single widened adder; the extra top bit is the carry out of bit 63.
  assign sum   = {1'b0, a2} + {1'b0, b2} + {{WIDTH{1'b0}}, C0};
  // Only the low six bits set the shift amount; B[63:6] is ignored.
  assign shamt = B[SHW-1:0];

  // Select the result and derive the flags from the chosen operation.
  always_comb begin
    f_d  = '0;
    st_d = '0;
    case (FS[4:2])
      3'b000: f_d = a2 & b2;
      3'b001: f_d = a2 | b2;
      3'b010: begin
        f_d    = sum[WIDTH-1:0];
        st_d.c = sum[WIDTH];
        // Overflow: both operands share a sign and the result sign differs.
        st_d.v = (a2[WIDTH-1] == b2[WIDTH-1]) && (sum[WIDTH-1] != a2[WIDTH-1]);
      end
      3'b011: f_d = a2 ^ b2;
      // Shifts take the raw A, so FS[1:0] has no effect on them.
      3'b100: f_d = A << shamt;
      3'b101: f_d = A >> shamt;
`ifdef ALU_ASR_EN
      3'b110: f_d = $signed(A) >>> shamt;
`endif
      default: f_d = '0;
    endcase
    st_d.n = f_d[WIDTH-1];
    st_d.z = (f_d == '0);
  end

  // Output registers. Reset takes priority and drops the operation presented
  // in the same cycle. Without in_valid, the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= '0;
      st_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        f_q  <= f_d;
        st_q <= st_d;
      end
    end
  end

  assign F         = f_q;
  assign status    = st_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_legv8_core.sv
// tb_alu_legv8_core: scoreboard bench for alu_legv8_core.
// The stimulus process queues the expected per-cycle response from an
// arithmetic reference model. A monitor pops one entry after each clock edge
// and compares it with the DUT.
module tb_alu_legv8_core;

  logic        clk = 1'b0;
  logic        rst, in_valid, C0;
  logic [63:0] A, B, F;
  logic [4:0]  FS;
  logic [3:0]  status;
  logic        out_valid;

  always #5 clk = ~clk;

  alu_legv8_core #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .FS(FS), .C0(C0),
    .F(F), .status(status), .out_valid(out_valid)
  );

  typedef struct {
    logic        vld;
    logic [63:0] f;
    logic [3:0]  s;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mF;
  logic [3:0]  mS;

  // Reference model: plain arithmetic on the operation rules.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] fs, input logic c0,
                                output logic [63:0] f, output logic [3:0] s);
    logic [63:0]        a2, b2;
    logic [64:0]        full;
    logic signed [65:0] ss;
    logic               cf, vf;
    int                 amt;
    a2  = fs[1] ? ~a : a;
    b2  = fs[0] ? ~b : b;
    cf  = 1'b0;
    vf  = 1'b0;
    amt = int'(b % 64);
    f   = '0;
    case (fs[4:2])
      3'd0: f = a2 & b2;
      3'd1: f = a2 | b2;
      3'd2: begin
        full = {1'b0, a2} + {1'b0, b2} + {64'd0, c0};
        f    = full[63:0];
        cf   = full[64];
        ss   = $signed({{2{a2[63]}}, a2}) + $signed({{2{b2[63]}}, b2})
             + $signed({65'd0, c0});
        // Signed overflow: the exact sum does not fit in 64 signed bits.
        vf   = (ss != $signed({{2{f[63]}}, f}));
      end
      3'd3: f = a2 ^ b2;
      3'd4: begin f = a; for (int i = 0; i < amt; i++) f = f * 2; end
      3'd5: begin f = a; for (int i = 0; i < amt; i++) f = f / 2; end
`ifdef ALU_ASR_EN
      3'd6: begin
        f = a;
        for (int i = 0; i < amt; i++) f = (f / 2) | (a[63] ? 64'h8000_0000_0000_0000 : 64'd0);
      end
`endif
      default: f = '0;
    endcase
    s = {vf, cf, f[63], (f == 64'd0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic step(input logic r, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] fs, input logic c0);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b; FS = fs; C0 = c0;
    if (r) begin
      mF = '0; mS = '0;
    end else if (v) begin
      model(a, b, fs, c0, mF, mS);
    end
    e.vld = v && !r;
    e.f   = mF;
    e.s   = mS;
    sbq.push_back(e);
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] x;
    case ($urandom_range(0, 4))
      0: x = 64'hFFFF_FFFF_FFFF_FFFF;
      1: x = 64'h8000_0000_0000_0000;
      2: x = 64'h7FFF_FFFF_FFFF_FFFF;
      3: x = 64'($urandom_range(0, 255));
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  // Monitor: compare each registered output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_valid", {63'd0, out_valid}, {63'd0, e.vld});
        chk("F", F, e.f);
        chk("status", {60'd0, status}, {60'd0, e.s});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; FS = '0; C0 = 1'b0;
    mF = '0; mS = '0;

    step(1, 1, 64'd1, 64'd1, 5'b01000, 1'b0);           // reset beats a valid op
    step(0, 1, 64'd1, 64'd1, 5'b01000, 1'b0);           // F=2
    step(0, 1, 64'h6, 64'h3, 5'b00000, 1'b0);           // AND  -> 2
    step(0, 1, 64'h6, 64'h3, 5'b00100, 1'b0);           // OR   -> 7
    step(0, 1, 64'h6, 64'h3, 5'b01100, 1'b0);           // XOR  -> 5
    step(0, 1, 64'h6, 64'h3, 5'b00011, 1'b0);           // NOR  -> ..F8, N
    step(0, 1, ones, 64'd1, 5'b01000, 1'b0);            // carry + zero
    step(0, 1, 64'd5, 64'd5, 5'b01001, 1'b1);           // 5-5
    step(0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0); // overflow
    step(0, 1, 64'd1, 64'd63, 5'b10000, 1'b0);          // LSL 63
    step(0, 1, 64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0); // LSR 63
    step(0, 1, 64'h1234, 64'h40, 5'b10000, 1'b0);       // only B[5:0]
    step(0, 1, 64'h1234, 64'd0, 5'b10100, 1'b0);        // shift by 0
    step(0, 1, ones, ones, 5'b11100, 1'b0);             // undefined -> 0, Z
    step(0, 1, 64'h8000_0000_0000_0000, 64'd4, 5'b11000, 1'b0); // ASR or zero
    step(0, 0, 64'd77, 64'd9, 5'b01000, 1'b1);          // hold
    step(0, 0, ones, 64'd3, 5'b00011, 1'b0);            // hold
    step(0, 1, 64'd3, 64'd4, 5'b01000, 1'b0);
    step(1, 1, ones, ones, 5'b01000, 1'b1);             // mid-stream reset
    step(0, 0, 64'd1, 64'd1, 5'b01000, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic r, v;
      logic [63:0] a, b;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = pick();
      b = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 127)) : pick();
      step(r, v, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    step(0, 0, 64'd0, 64'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
